rr_bus_arbiter4: RTL and testbench

Round-robin arbiter and sequencer sharing one registered 16-bit result bus among four requesters (ALU result, shifter, flag/status unit, external load path). Grants one requester at a time for a burst of beats and steers its data through the existing 4-to-1 16-bit mux into an output register. The output side uses a valid/ready handshake toward the writeback stage.

---
 rtl/arb_pkg.sv | 34 +++
 rtl/mux4to1_16bit.sv | 23 ++
 rtl/rr_bus_arbiter4.sv | 149 ++++++++++++++
 tb/tb_rr_bus_arbiter4.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and rotate-priority helper for the
// four-way result-bus arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Return the first set index of req, searching start, start+1, ... mod 4.
  // Scans from the far end back toward start so the nearest hit wins.
  // Only meaningful when req is non-zero; otherwise start is returned.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [SEL_W-1:0]   start
  );
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (req[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4to1_16bit.sv
// Existing 4-to-1 16-bit data mux used to steer the owner's data onto the bus.
module mux4to1_16bit (
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  // Select one of the four inputs by sel.
  always_comb begin
    out = 16'h0000;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = 16'h0000;
    endcase
  end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin burst arbiter sharing one registered 16-bit result bus among
// four requesters, with a valid/ready output toward writeback.
module rr_bus_arbiter4
  import arb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [3:0]        last,
  output logic [3:0]        ack,
  output logic [3:0]        grant,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [1:0]        out_src,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [3:0] BURST_END = 4'(MAX_BURST - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_nxt_s;
  logic [SEL_W-1:0] owner_r;
  logic [SEL_W-1:0] owner_nxt_s;
  logic [3:0]       beat_cnt_r;
  logic [3:0]       beat_cnt_nxt_s;
  logic [3:0]       grant_nxt_s;
  logic [SEL_W-1:0] pick_s;
  logic             req_sel_s;
  logic             last_sel_s;
  logic             load_s;
  logic             end_burst_s;
  logic [15:0]      mux_data_s;

  assign pick_s      = rr_pick(req, ptr_r);
  assign req_sel_s   = req[owner_r];
  assign last_sel_s  = last[owner_r];
  // A beat moves only when the owner has one and the output slot is free or
  // being emptied this same edge; ack therefore never depends on in*.
  assign load_s      = (state_r == GRANT) && req_sel_s && (!out_valid || out_ready);
  assign end_burst_s = load_s && (last_sel_s || (beat_cnt_r == BURST_END));
  assign busy        = (state_r == GRANT);

  mux4to1_16bit u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (owner_r),
    .out (mux_data_s)
  );

  // Acknowledge the owner's beat on the cycle it is captured.
  always_comb begin
    ack = 4'b0000;
    if (load_s) begin
      ack = 4'b0001 << owner_r;
    end else begin
      ack = 4'b0000;
    end
  end

  // Next-state logic: arbitration in IDLE, burst sequencing and release in GRANT.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    owner_nxt_s    = owner_r;
    beat_cnt_nxt_s = beat_cnt_r;
    grant_nxt_s    = grant;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s    = GRANT;
          owner_nxt_s    = pick_s;
          grant_nxt_s    = 4'b0001 << pick_s;
          beat_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (!req_sel_s || end_burst_s) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = owner_r + 2'd1;
          grant_nxt_s = 4'b0000;
        end else begin
          state_nxt_s = GRANT;
        end
        if (load_s) begin
          beat_cnt_nxt_s = beat_cnt_r + 4'd1;
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        grant_nxt_s    = 4'b0000;
        beat_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      owner_r    <= 2'd0;
      beat_cnt_r <= 4'd0;
      grant      <= 4'b0000;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      owner_r    <= owner_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      grant      <= grant_nxt_s;
    end
  end

  // Output register: load a new beat, drain an accepted one, or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= 2'd0;
    end else if (load_s) begin
      out_data  <= mux_data_s;
      out_valid <= 1'b1;
      out_last  <= last_sel_s;
      out_src   <= owner_r;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Self-checking bench for rr_bus_arbiter4: a cycle model predicts ack, grant,
// busy and out_valid; captured beats are queued and compared when accepted.
module tb_rr_bus_arbiter4;

  localparam int MAX_BURST = 4;

  typedef struct {
    logic [1:0]  src;
    logic [15:0] data;
    logic        lst;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] in0, in1, in2, in3;
  logic [3:0]  last;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int ack2_cnt = 0;

  beat_t      sb_q[$];
  logic [1:0] src_log[$];

  // reference model state
  logic       m_state;
  logic [1:0] m_ptr;
  logic [1:0] m_owner;
  int         m_cnt;
  logic [3:0] m_grant;
  logic       m_ovalid;

  rr_bus_arbiter4 #(.DATA_W(16), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .last      (last),
    .ack       (ack),
    .grant     (grant),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] in_of(input logic [1:0] i);
    case (i)
      2'd0:    return in0;
      2'd1:    return in1;
      2'd2:    return in2;
      default: return in3;
    endcase
  endfunction

  // One clock cycle: check settled outputs against the model, score accepted
  // beats, advance the model across the edge, and return 1 time unit after it.
  task automatic tick();
    logic       ld;
    logic [3:0] exp_ack;
    logic       found;
    logic [1:0] idx;
    beat_t      b;
    beat_t      nb;
    #1;
    ld      = m_state && req[m_owner] && (!m_ovalid || out_ready);
    exp_ack = ld ? (4'b0001 << m_owner) : 4'b0000;
    chk_val("ack", ack, exp_ack);
    chk_val("busy", busy, m_state);
    chk_val("grant", grant, m_grant);
    chk_val("out_valid", out_valid, m_ovalid);
    if (ack[2]) ack2_cnt++;
    if (out_valid && out_ready && rst_n) begin
      if (sb_q.size() == 0) begin
        chk_val("sb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        b = sb_q.pop_front();
        chk_val("sb_data", out_data, b.data);
        chk_val("sb_src", out_src, b.src);
        chk_val("sb_last", out_last, b.lst);
        src_log.push_back(out_src);
      end
    end
    if (!rst_n) begin
      m_state = 1'b0; m_ptr = 2'd0; m_owner = 2'd0; m_cnt = 0;
      m_grant = 4'b0000; m_ovalid = 1'b0;
      sb_q.delete();
    end else begin
      if (ld) begin
        nb.src = m_owner; nb.data = in_of(m_owner); nb.lst = last[m_owner];
        sb_q.push_back(nb);
        m_ovalid = 1'b1;
      end else if (m_ovalid && out_ready) begin
        m_ovalid = 1'b0;
      end
      if (!m_state) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          idx = m_ptr + k[1:0];
          if (!found && req[idx]) begin
            found = 1'b1; m_owner = idx;
          end
        end
        if (found) begin
          m_state = 1'b1; m_grant = 4'b0001 << m_owner; m_cnt = 0;
        end
      end else if (!req[m_owner]) begin
        m_state = 1'b0; m_ptr = m_owner + 2'd1; m_grant = 4'b0000;
      end else if (ld) begin
        m_cnt++;
        if (last[m_owner] || m_cnt == MAX_BURST) begin
          m_state = 1'b0; m_ptr = m_owner + 2'd1; m_grant = 4'b0000;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; last = 4'b0000; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; last = 4'b0000; out_ready = 1'b1;
    in0 = 16'h0000; in1 = 16'h0000; in2 = 16'h0000; in3 = 16'h0000;
    m_state = 1'b0; m_ptr = 2'd0; m_owner = 2'd0; m_cnt = 0;
    m_grant = 4'b0000; m_ovalid = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    chk_val("rst_grant", grant, 32'h0);
    chk_val("rst_valid", out_valid, 32'h0);
    chk_val("rst_data", out_data, 32'h0);
    chk_val("rst_src", out_src, 32'h0);
    chk_val("rst_last", out_last, 32'h0);
    chk_val("rst_busy", busy, 32'h0);
    rst_n = 1'b1;

    // 1: single burst of three beats from requester 0
    req = 4'b0001; in0 = 16'h1111;
    tick();
    chk_val("t1_grant", grant, 32'h1);
    tick();
    chk_val("t1_beat1", out_data, 32'h1111);
    in0 = 16'h2222;
    tick();
    chk_val("t1_beat2", out_data, 32'h2222);
    in0 = 16'h3333; last = 4'b0001;
    tick();
    chk_val("t1_beat3", out_data, 32'h3333);
    chk_val("t1_last", out_last, 32'h1);
    chk_val("t1_idle", busy, 32'h0);
    req = 4'b0000; last = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    chk_val("t1_ptr1", grant, 32'h8);
    req = 4'b0000;
    tick();

    // 2: round-robin fairness, one-beat bursts
    do_reset();
    src_log.delete();
    in0 = 16'h0A00; in1 = 16'h0A01; in2 = 16'h0A02; in3 = 16'h0A03;
    req = 4'b1111; last = 4'b1111;
    for (int c = 0; c < 10; c++) tick();
    req = 4'b0000; last = 4'b0000;
    tick();
    tick();
    chk_val("t2_nbeats", src_log.size(), 32'd5);
    if (src_log.size() >= 5) begin
      chk_val("t2_src0", src_log[0], 32'd0);
      chk_val("t2_src1", src_log[1], 32'd1);
      chk_val("t2_src2", src_log[2], 32'd2);
      chk_val("t2_src3", src_log[3], 32'd3);
      chk_val("t2_src4", src_log[4], 32'd0);
    end

    // 3: burst cap on requester 2, then pointer wrap past 3
    do_reset();
    in2 = 16'hA5A5; req = 4'b0100; ack2_cnt = 0;
    for (int c = 0; c < 5; c++) tick();
    chk_val("t3_ack_count", ack2_cnt, 32'd4);
    chk_val("t3_release", busy, 32'h0);
    req = 4'b0110;
    tick();
    chk_val("t3_next_grant", grant, 32'h2);
    req = 4'b0000;
    tick();
    tick();

    // 4: backpressure freezes the output and the burst
    do_reset();
    req = 4'b0001; in0 = 16'h1111;
    tick();
    tick();
    out_ready = 1'b0; in0 = 16'h2222;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_val("t4_hold_data", out_data, 32'h1111);
      chk_val("t4_hold_valid", out_valid, 32'h1);
    end
    out_ready = 1'b1;
    tick();
    chk_val("t4_resume", out_data, 32'h2222);
    in0 = 16'h3333; last = 4'b0001;
    tick();
    req = 4'b0000; last = 4'b0000;
    tick();
    tick();

    // 5: owner withdraws; pending beat still drains
    do_reset();
    req = 4'b0010; in1 = 16'h5151;
    tick();
    tick();
    out_ready = 1'b0; req = 4'b0000;
    tick();
    chk_val("t5_idle", busy, 32'h0);
    chk_val("t5_pending", out_data, 32'h5151);
    out_ready = 1'b1;
    tick();
    chk_val("t5_drained", out_valid, 32'h0);
    req = 4'b0110;
    tick();
    chk_val("t5_ptr2", grant, 32'h4);
    req = 4'b0000;
    tick();

    // 6: reset mid-burst discards the beat
    do_reset();
    req = 4'b0100; in2 = 16'h7777;
    tick();
    out_ready = 1'b0;
    tick();
    chk_val("t6_pre_grant", grant, 32'h4);
    rst_n = 1'b0;
    tick();
    chk_val("t6_grant", grant, 32'h0);
    chk_val("t6_valid", out_valid, 32'h0);
    chk_val("t6_data", out_data, 32'h0);
    chk_val("t6_src", out_src, 32'h0);
    chk_val("t6_last", out_last, 32'h0);
    chk_val("t6_busy", busy, 32'h0);
    rst_n = 1'b1; out_ready = 1'b1; req = 4'b0101;
    tick();
    chk_val("t6_restart", grant, 32'h1);
    req = 4'b0000;
    tick();
    tick();

    chk_val("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
